// File: rtl/snake_body_ctl.sv
// snake_body_ctl: snake head/tail/score/direction game state, advanced one cell per tick.
// Ports: clk, reset, tick, start, dir_valid, dir_in, food_eaten -> head_x/y, tail_x/y, score, game_over, running. Option: SNAKE_WRAP_EN.
module snake_body_ctl #(
  parameter int GRID_W  = 64,
  parameter int GRID_H  = 48,
  parameter int START_X = 32,
  parameter int START_Y = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         start,
  input  logic         dir_valid,
  input  logic [1:0]   dir_in,
  input  logic         food_eaten,
  output logic [6:0]   head_x,
  output logic [5:0]   head_y,
  output logic [104:0] tail_x,
  output logic [89:0]  tail_y,
  output logic [3:0]   score,
  output logic         game_over,
  output logic         running
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_RIGHT = 2'd1;
  localparam logic [1:0] D_DOWN  = 2'd2;
  localparam logic [1:0] D_LEFT  = 2'd3;

  localparam logic signed [7:0] X_MAX = 8'(GRID_W - 1);
  localparam logic signed [6:0] Y_MAX = 7'(GRID_H - 1);

  state_t         r_state, w_state;
  logic [6:0]     r_hx, w_hx;
  logic [5:0]     r_hy, w_hy;
  logic [104:0]   r_tx, w_tx;
  logic [89:0]    r_ty, w_ty;
  logic [3:0]     r_score, w_score;
  logic [1:0]     r_cur, w_cur;
  logic [1:0]     r_nxt, w_nxt;
  logic           r_grow, w_grow;

  logic              w_dir_ok;
  logic [1:0]        w_mdir;
  logic signed [7:0] w_cx;
  logic signed [6:0] w_cy;
  logic [6:0]        w_nx;
  logic [5:0]        w_ny;
  logic              w_wall;
  logic              w_self;

  // Candidate head: one bit wider and signed so -1 and
  // GRID_W/GRID_H are visible before they are judged.
  always_comb begin
    // opposite direction differs only in bit 1
    w_dir_ok = dir_valid && (dir_in != (r_cur ^ 2'b10));
    // a request in the same cycle as tick steers that move
    w_mdir   = w_dir_ok ? dir_in : r_nxt;
    w_cx     = $signed({1'b0, r_hx});
    w_cy     = $signed({1'b0, r_hy});
    unique case (w_mdir)
      D_UP:    w_cy = w_cy - 7'sd1;
      D_RIGHT: w_cx = w_cx + 8'sd1;
      D_DOWN:  w_cy = w_cy + 7'sd1;
      D_LEFT:  w_cx = w_cx - 8'sd1;
      default: w_cx = w_cx;
    endcase
    w_nx   = w_cx[6:0];
    w_ny   = w_cy[5:0];
    w_wall = 1'b0;
`ifdef SNAKE_WRAP_EN
    if (w_cx[7])
      w_nx = 7'(GRID_W - 1);
    else if (w_cx > X_MAX)
      w_nx = '0;
    if (w_cy[6])
      w_ny = 6'(GRID_H - 1);
    else if (w_cy > Y_MAX)
      w_ny = '0;
`else
    w_wall = w_cx[7] || (w_cx > X_MAX)
          || w_cy[6] || (w_cy > Y_MAX);
`endif
    // every active segment counts, including the
    // one that would vacate its cell on this move
    w_self = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if ((4'(i) < r_score)
          && (r_tx[7*i +: 7] == w_nx)
          && (r_ty[6*i +: 6] == w_ny))
        w_self = 1'b1;
    end
  end

  always_comb begin
    w_state = r_state;
    w_hx    = r_hx;
    w_hy    = r_hy;
    w_tx    = r_tx;
    w_ty    = r_ty;
    w_score = r_score;
    w_cur   = r_cur;
    w_nxt   = r_nxt;
    w_grow  = r_grow;
    if (food_eaten)
      w_grow = 1'b1;
    if (w_dir_ok)
      w_nxt = dir_in;
    unique case (r_state)
      S_IDLE, S_DEAD: begin
        if (start) begin
          w_state = S_RUN;
          w_hx    = 7'(START_X);
          w_hy    = 6'(START_Y);
          w_tx    = '0;
          w_ty    = '0;
          w_score = '0;
          w_cur   = D_RIGHT;
          w_nxt   = D_RIGHT;
          w_grow  = 1'b0;
        end
      end
      S_RUN: begin
        if (tick) begin
          if (w_wall || w_self) begin
            w_state = S_DEAD;
          end else begin
            // full shift: the segment that becomes
            // active on growth already holds the
            // cell just vacated
            w_tx  = {r_tx[97:0], r_hx};
            w_ty  = {r_ty[83:0], r_hy};
            w_hx  = w_nx;
            w_hy  = w_ny;
            w_cur = w_mdir;
            w_nxt = w_mdir;
            if (r_grow || food_eaten) begin
              if (r_score != 4'd15)
                w_score = r_score + 4'd1;
              w_grow = 1'b0;
            end
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hx    <= 7'(START_X);
      r_hy    <= 6'(START_Y);
      r_tx    <= '0;
      r_ty    <= '0;
      r_score <= '0;
      r_cur   <= D_RIGHT;
      r_nxt   <= D_RIGHT;
      r_grow  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_hx    <= w_hx;
      r_hy    <= w_hy;
      r_tx    <= w_tx;
      r_ty    <= w_ty;
      r_score <= w_score;
      r_cur   <= w_cur;
      r_nxt   <= w_nxt;
      r_grow  <= w_grow;
    end
  end

  assign head_x    = r_hx;
  assign head_y    = r_hy;
  assign tail_x    = r_tx;
  assign tail_y    = r_ty;
  assign score     = r_score;
  assign game_over = (r_state == S_DEAD);
  assign running   = (r_state == S_RUN);

endmodule
